qq_head: RTL and testbench
==========================

# qq_head

Front-end stage of the quick-queue priority queue, directly upstream of the first `qq_node` in the chain. It turns user push/pop valid/ready handshakes into single-cycle `enq`/`deq` pulses on the node's left-side port. It tracks occupancy and returns the minimum key on pop. It arbitrates simultaneous push and pop, and never issues a new operation until the node reports ready again.

## Interface
- `W`, 32, key width; must match the node chain.
- `D`, 4, entries per node.
- `N`, 1, number of nodes in the chain.
- `CAP` (localparam), `D*N`, total capacity.
- `CW` (localparam), `$clog2(CAP+1)`, count width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `enq_valid`  in  1  user push request.
- `enq_key`  in  W  key to push; all-ones (`MAX_KEY`) is reserved.
- `enq_ready`  out  1  push accepted this cycle.
- `pop_valid`  in  1  user pop request.
- `pop_ready`  out  1  pop accepted this cycle.
- `res_valid`  out  1  popped key available.
- `res_key`  out  W  popped (minimum) key.
- `res_ready`  in  1  consumer takes `res_key`.
- `node_rdy_i`  in  1  node 0 `rdy`.
- `node_empty_i`  in  1  node 0 `empty`.
- `node_key_i`  in  W  node 0 `data_lt_o`; current minimum key.
- `node_enq_o`  out  1  to node 0 `enq_i`.
- `node_deq_o`  out  1  to node 0 `deq_i`.
- `node_key_o`  out  W  to node 0 `data_lt_i`.
- `count`  out  CW  stored keys.
- `full`  out  1  `count==CAP`.
- `empty`  out  1  `count==0`.
- `err`  out  1  sticky error flag.

## Operation
- FSM states: IDLE, HOLD, WAIT.
- IDLE → HOLD when an operation issues. HOLD → WAIT unconditionally. WAIT → IDLE when `node_rdy_i=1`.
- Push eligible: state IDLE, `node_rdy_i`, `!full`, `enq_valid`.
- Pop eligible: state IDLE, `node_rdy_i`, `!empty`, `pop_valid`, and the result slot is free (`!res_valid || res_ready`).
- Arbitration:
  - Only one eligible: it is granted.
  - Both eligible: grant the opposite of `last_op`. `last_op` resets to POP, so push wins first.
- Push grant, same cycle:
  - `enq_ready=1`, `node_enq_o=1`, `node_key_o=enq_key`.
  - If `enq_key==MAX_KEY`, drive `MAX_KEY-1` and set `err`.
  - `count+1`; `last_op<=PUSH`.
- Pop grant, same cycle:
  - `pop_ready=1`, `node_deq_o=1`.
  - `res_key<=node_key_i`, `res_valid<=1`.
  - `count-1`; `last_op<=POP`.
- `res_valid` clears on `res_ready` when no pop is granted in the same cycle.
- A pop grant with `res_ready=1` replaces `res_key` with no bubble.
- Consistency checks, evaluated in IDLE with `node_rdy_i=1`; either one sets `err`:
  - `node_empty_i != empty`.
  - `node_key_i==MAX_KEY` while `!empty`.
- `err` clears only on reset.
- `node_key_o` is `0` whenever `node_enq_o=0`.

## Timing
- Reset values:
  - state IDLE, `count=0`, `empty=1`, `full=0`.
  - `res_valid=0`, `res_key=0`, `err=0`, `last_op=POP`.
  - `enq_ready`, `pop_ready`, `node_enq_o`, `node_deq_o` all `0`.
  - `node_key_o=0`.
- `enq_ready`, `pop_ready`, `node_enq_o` and `node_deq_o` are combinational from state, flags, `node_rdy_i` and the valids. Each is a one-cycle pulse.
- HOLD masks `node_rdy_i` for one cycle, covering the node's one-cycle lag in dropping `rdy`.
- Minimum spacing between operations is 3 cycles (issue, HOLD, WAIT with `rdy=1`).
- Pop latency: `res_valid` rises the cycle after `pop_ready`.
- `count`, `full` and `empty` update the cycle after a grant.
- Reset mid-operation returns everything to reset values immediately. The node shares `rst`, so no drain is needed.

## Structure
- Shared package `qq_pkg`:
  - `qq_head_state_t` enum.
  - `qq_op_t` enum (PUSH, POP).
  - `function max_key(W)`.
- One sub-module, `qq_rr_arb2`: 2-request round-robin arbiter holding `last_op`.
- Result register uses the existing `dffre`.

## Test plan
- Reset, then push 5, 3, 9 with `node_rdy_i` modelled as low for 2 cycles after each op → `count=3`, exactly three `node_enq_o` pulses at least 3 cycles apart.
- Pop three times with `res_ready=1` → `res_key` 3, 5, 9; `empty=1`; a fourth `pop_valid` sees `pop_ready=0`.
- `enq_valid` and `pop_valid` held together with `count=2` → grants alternate push, pop, push, and so on; `count` oscillates between 2 and 3.
- Fill to `CAP=4` → `full=1`, `enq_ready` stays 0; one pop → `full=0` the next cycle.
- `res_ready=0` after one pop with `pop_valid` held → no second pop grant until `res_ready=1`; `res_key` stays stable.
- Push `32'hFFFFFFFF` → `node_key_o=32'hFFFFFFFE`, `err=1`. Asserting `rst` during WAIT → all reset values, `err=0`.

Source files
------------

// File: rtl/qq_pkg.sv
// qq_pkg: shared types and helpers for the quick-queue front end
package qq_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, WAIT} qq_head_state_t;
  typedef enum logic {PUSH, POP} qq_op_t;
  function automatic logic [63:0] max_key(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/qq_head_if.sv
// qq_head_if: user-side push/pop/result handshake and status of the queue head
interface qq_head_if #(parameter int W = 32, parameter int CW = 3);
  logic enq_valid, enq_ready, pop_valid, pop_ready, res_valid, res_ready;
  logic full, empty, err;
  logic [W-1:0] enq_key, res_key;
  logic [CW-1:0] count;
  modport master (output enq_valid, enq_key, pop_valid, res_ready,
                  input enq_ready, pop_ready, res_valid, res_key, count, full, empty, err);
  modport slave (input enq_valid, enq_key, pop_valid, res_ready,
                 output enq_ready, pop_ready, res_valid, res_key, count, full, empty, err);
endinterface

// File: rtl/dffre.sv
// dffre: enabled register with asynchronous active-high reset to zero
module dffre #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/qq_rr_arb2.sv
// qq_rr_arb2: push/pop round-robin arbiter remembering the last granted op
module qq_rr_arb2 import qq_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic req_push_i,
  input  logic req_pop_i,
  output logic gnt_push_o,
  output logic gnt_pop_o
);
  qq_op_t last_q, last_d;
  always_comb begin
    gnt_push_o = req_push_i & (~req_pop_i | (last_q == POP));
    gnt_pop_o = req_pop_i & (~req_push_i | (last_q == PUSH));
    last_d = gnt_push_o ? PUSH : gnt_pop_o ? POP : last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= POP;
    else last_q <= last_d;
endmodule

// File: rtl/qq_head.sv
// qq_head: turns user push/pop handshakes into enq/deq pulses for the first qq_node
module qq_head import qq_pkg::*; #(
  parameter int W = 32,
  parameter int D = 4,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  qq_head_if.slave     u,
  input  logic         node_rdy_i,
  input  logic         node_empty_i,
  input  logic [W-1:0] node_key_i,
  output logic         node_enq_o,
  output logic         node_deq_o,
  output logic [W-1:0] node_key_o
);
  localparam int CAP = D * N;
  localparam int CW = $clog2(CAP + 1);
  localparam logic [W-1:0] MAXK = W'(max_key(W));
  qq_head_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic err_q, err_d, res_valid_q, res_valid_d;
  logic idle_rdy, push_el, pop_el, gnt_push, gnt_pop;
  assign u.count = count_q;
  assign u.full = count_q == CW'(CAP);
  assign u.empty = count_q == '0;
  assign u.err = err_q;
  assign u.res_valid = res_valid_q;
  assign idle_rdy = (state_q == IDLE) & node_rdy_i;
  assign push_el = idle_rdy & ~u.full & u.enq_valid;
  assign pop_el = idle_rdy & ~u.empty & u.pop_valid & (~res_valid_q | u.res_ready);
  qq_rr_arb2 u_arb (.clk(clk), .rst(rst), .req_push_i(push_el), .req_pop_i(pop_el),
                    .gnt_push_o(gnt_push), .gnt_pop_o(gnt_pop));
  dffre #(.W(W)) u_res (.clk(clk), .rst(rst), .en_i(gnt_pop), .d_i(node_key_i), .q_o(u.res_key));
  // HOLD ignores rdy for a cycle because the node drops it one cycle late
  always_comb begin
    state_d = (state_q == IDLE) ? ((gnt_push | gnt_pop) ? HOLD : IDLE) :
              (state_q == HOLD) ? WAIT : (node_rdy_i ? IDLE : WAIT);
    count_d = count_q + CW'(gnt_push) - CW'(gnt_pop);
    res_valid_d = gnt_pop | (res_valid_q & ~u.res_ready);
    err_d = err_q | (gnt_push & (u.enq_key == MAXK)) |
            (idle_rdy & ((node_empty_i != u.empty) | (~u.empty & (node_key_i == MAXK))));
    u.enq_ready = gnt_push;
    u.pop_ready = gnt_pop;
    node_enq_o = gnt_push;
    node_deq_o = gnt_pop;
    node_key_o = gnt_push ? ((u.enq_key == MAXK) ? MAXK - 1'b1 : u.enq_key) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q <= err_d;
      res_valid_q <= res_valid_d;
    end
endmodule

// File: tb/tb_qq_head.sv
// tb_qq_head: directed checks of qq_head against a small sorted-node model
module tb_qq_head;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  qq_head_if #(.W(32), .CW(3)) u ();
  logic node_rdy, node_empty, node_enq, node_deq;
  logic [31:0] node_key_in, node_key_out;
  qq_head #(.W(32), .D(4), .N(1)) dut (
    .clk(clk), .rst(rst), .u(u), .node_rdy_i(node_rdy), .node_empty_i(node_empty),
    .node_key_i(node_key_in), .node_enq_o(node_enq), .node_deq_o(node_deq),
    .node_key_o(node_key_out));
  // node model: sorted store, rdy low for two cycles after each op
  logic [31:0] m [4];
  int mn, busy;
  assign node_empty = (mn == 0);
  assign node_key_in = (mn == 0) ? 32'hFFFFFFFF : m[0];
  assign node_rdy = (busy == 0);
  always @(posedge clk or posedge rst)
    if (rst) begin
      mn <= 0;
      busy <= 0;
      for (int i = 0; i < 4; i++) m[i] <= 32'hFFFFFFFF;
    end else begin
      automatic logic [31:0] t [4];
      automatic int c;
      automatic int p;
      t = m;
      c = mn;
      if (node_deq && c > 0) begin
        for (int i = 0; i < 3; i++) t[i] = t[i+1];
        t[3] = 32'hFFFFFFFF;
        c--;
      end
      if (node_enq && c < 4) begin
        p = c;
        while (p > 0 && t[p-1] > node_key_out) begin
          t[p] = t[p-1];
          p--;
        end
        t[p] = node_key_out;
        c++;
      end
      m <= t;
      mn <= c;
      busy <= (node_enq || node_deq) ? 2 : (busy > 0 ? busy - 1 : 0);
    end
  int cyc = 0, enq_pulses = 0, last_op_cyc = -100, min_gap = 1000;
  always @(posedge clk) begin
    cyc++;
    if (node_enq) enq_pulses++;
    if (node_enq || node_deq) begin
      if (cyc - last_op_cyc < min_gap) min_gap = cyc - last_op_cyc;
      last_op_cyc = cyc;
    end
  end
  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_idle();
    repeat (8) @(negedge clk);
  endtask
  task automatic push(input logic [31:0] k);
    int n;
    u.enq_valid = 1'b1;
    u.enq_key = k;
    #1;
    n = 0;
    while (!u.enq_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("push_grant", u.enq_ready, 1);
    @(negedge clk);
    u.enq_valid = 1'b0;
  endtask
  task automatic pop(input logic [31:0] exp);
    int n;
    u.pop_valid = 1'b1;
    #1;
    n = 0;
    while (!u.pop_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pop_grant", u.pop_ready, 1);
    @(negedge clk);
    u.pop_valid = 1'b0;
    chk("pop_res_valid", u.res_valid, 1);
    chk("pop_res_key", u.res_key, exp);
  endtask
  initial begin
    int n, g;
    logic seen;
    u.enq_valid = 1'b0;
    u.enq_key = '0;
    u.pop_valid = 1'b0;
    u.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", u.count, 0);
    chk("rst_empty", u.empty, 1);
    chk("rst_full", u.full, 0);
    chk("rst_res_valid", u.res_valid, 0);
    chk("rst_res_key", u.res_key, 0);
    chk("rst_err", u.err, 0);
    chk("rst_node_key_o", node_key_out, 0);
    chk("rst_pop_ready", u.pop_ready, 0);
    push(5);
    push(3);
    push(9);
    wait_idle();
    chk("fill3_count", u.count, 3);
    chk("fill3_pulses", enq_pulses, 3);
    chk("fill3_gap_ge3", min_gap >= 3, 1);
    chk("fill3_err", u.err, 0);
    pop(3);
    pop(5);
    pop(9);
    wait_idle();
    chk("drain_empty", u.empty, 1);
    chk("drain_count", u.count, 0);
    chk("drain_res_valid", u.res_valid, 0);
    u.pop_valid = 1'b1;
    #1;
    seen = u.pop_ready;
    repeat (8) begin
      @(negedge clk);
      seen |= u.pop_ready;
    end
    u.pop_valid = 1'b0;
    chk("pop_when_empty", seen, 0);
    push(10);
    push(20);
    push(30);
    pop(10);
    wait_idle();
    chk("alt_start_count", u.count, 2);
    u.enq_valid = 1'b1;
    u.enq_key = 32'd7;
    u.pop_valid = 1'b1;
    #1;
    g = 0;
    n = 0;
    while (g < 4 && n < 40) begin
      if (u.enq_ready || u.pop_ready) begin
        chk("alt_is_push", u.enq_ready, (g % 2 == 0));
        chk("alt_count", u.count, (g % 2 == 0) ? 2 : 3);
        g++;
      end
      @(negedge clk);
      #1;
      n++;
    end
    u.enq_valid = 1'b0;
    u.pop_valid = 1'b0;
    chk("alt_grants", g, 4);
    chk("alt_res_key", u.res_key, 7);
    wait_idle();
    chk("alt_end_count", u.count, 2);
    push(1);
    push(2);
    wait_idle();
    chk("full_flag", u.full, 1);
    chk("full_count", u.count, 4);
    u.enq_valid = 1'b1;
    u.enq_key = 32'd40;
    #1;
    seen = u.enq_ready;
    repeat (8) begin
      @(negedge clk);
      seen |= u.enq_ready;
    end
    u.enq_valid = 1'b0;
    chk("push_when_full", seen, 0);
    pop(1);
    chk("full_clears", u.full, 0);
    wait_idle();
    u.res_ready = 1'b0;
    pop(2);
    u.pop_valid = 1'b1;
    #1;
    seen = u.pop_ready;
    repeat (10) begin
      @(negedge clk);
      seen |= u.pop_ready;
    end
    chk("bp_no_grant", seen, 0);
    chk("bp_res_key", u.res_key, 2);
    chk("bp_res_valid", u.res_valid, 1);
    u.res_ready = 1'b1;
    #1;
    chk("bp_release_grant", u.pop_ready, 1);
    @(negedge clk);
    u.pop_valid = 1'b0;
    chk("bp_next_key", u.res_key, 20);
    chk("bp_next_valid", u.res_valid, 1);
    wait_idle();
    chk("bp_count", u.count, 1);
    chk("bp_res_cleared", u.res_valid, 0);
    chk("pre_max_err", u.err, 0);
    u.enq_valid = 1'b1;
    u.enq_key = 32'hFFFFFFFF;
    #1;
    n = 0;
    while (!u.enq_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("max_node_enq", node_enq, 1);
    chk("max_node_key", node_key_out, 32'hFFFFFFFE);
    @(negedge clk);
    u.enq_valid = 1'b0;
    chk("max_err", u.err, 1);
    chk("max_count", u.count, 2);
    chk("idle_node_key_o", node_key_out, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_count", u.count, 0);
    chk("arst_err", u.err, 0);
    chk("arst_empty", u.empty, 1);
    chk("arst_full", u.full, 0);
    chk("arst_res_valid", u.res_valid, 0);
    chk("arst_res_key", u.res_key, 0);
    chk("arst_node_enq", node_enq, 0);
    chk("arst_node_deq", node_deq, 0);
    @(negedge clk);
    rst = 1'b0;
    push(5);
    wait_idle();
    chk("post_rst_count", u.count, 1);
    chk("post_rst_err", u.err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
